// File: rtl/gnn_agg_pkg.sv
// Shared types and helpers for the GNN neighbour aggregator.
// Holds the FSM state enum, the aggregation mode enum and the width check.
package gnn_agg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef enum logic {
        SUM = 1'b0,
        MAX = 1'b1
    } mode_e;

    // True when OW can hold the sum of N_NODES inputs of width IW.
    function automatic bit width_ok(input int iw, input int ow, input int nn);
        return ow >= iw + $clog2(nn + 1);
    endfunction

endpackage

// File: rtl/gnn_agg_node_acc.sv
// Per-destination accumulator bank: N_FEAT lanes of SUM or MAX.
// The first contribution in MAX mode loads the lane directly.
module gnn_agg_node_acc
    import gnn_agg_pkg::*;
#(
    parameter int N_FEAT = 4,
    parameter int IW     = 5,
    parameter int OW     = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_i,
    input  logic                 en_i,
    input  mode_e                mode_i,
    input  logic [N_FEAT*IW-1:0] x_i,
    output logic [N_FEAT*OW-1:0] acc_o
);

    logic [N_FEAT*OW-1:0] acc_q, acc_d;
    logic                 seen_q, seen_d;

    function automatic logic [OW-1:0] upd(
        input logic signed [OW-1:0] a,
        input logic        [IW-1:0] x,
        input mode_e                m,
        input logic                 seen
    );
        logic signed [OW-1:0] s;
        s = {{(OW-IW){x[IW-1]}}, x};
        if (m == SUM)
            return a + s;
        else if (!seen || s > a)
            return s;
        else
            return a;
    endfunction

    // Next-state for every feature lane of this destination.
    always_comb begin
        acc_d  = acc_q;
        seen_d = seen_q;
        if (init_i) begin
            acc_d  = '0;
            seen_d = 1'b0;
        end else if (en_i) begin
            seen_d = 1'b1;
            for (int f = 0; f < N_FEAT; f++) begin
                acc_d[f*OW +: OW] = upd(acc_q[f*OW +: OW],
                                        x_i[f*IW +: IW],
                                        mode_i, seen_q);
            end
        end
    end

    // Accumulator and first-contribution flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            seen_q <= seen_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/gnn_aggregator_param.sv
// GNN neighbour aggregation: one source node per cycle, SUM or MAX.
// Job captured on accept, result held until acknowledged.
module gnn_aggregator_param
    import gnn_agg_pkg::*;
#(
    parameter int N_NODES = 4,
    parameter int N_FEAT  = 4,
    parameter int IW      = 5,
    parameter int OW      = 21
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_rdy_agg,
    output logic                          in_ack,
    input  logic [N_NODES*N_FEAT*IW-1:0]  x_in,
    input  logic [N_NODES*N_NODES-1:0]    adj_in,
    input  logic                          self_loop,
    input  logic                          mode,
    output logic                          out_rdy_agg,
    input  logic                          out_ack,
    output logic [N_NODES*N_FEAT*OW-1:0]  x_agg
);

    localparam int CW  = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int NW  = N_FEAT * IW;
    localparam int NOW = N_FEAT * OW;
    localparam int AW  = N_NODES * N_NODES;

    if (!width_ok(IW, OW, N_NODES)) begin : g_width_bad
        $error("OW too narrow for IW and N_NODES");
    end

    function automatic logic [AW-1:0] diag_mask();
        logic [AW-1:0] d;
        d = '0;
        for (int i = 0; i < N_NODES; i++)
            d[i*N_NODES + i] = 1'b1;
        return d;
    endfunction

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [N_NODES*NW-1:0]    x_q;
    logic [AW-1:0]            adj_q;
    mode_e                    mode_q;
    logic                     accept;
    logic [AW-1:0]            adj_eff;
    logic [NW-1:0]            src_x;
    logic [N_NODES*NOW-1:0]   acc_all;

    assign accept  = (state_q == IDLE) && in_rdy_agg;
    assign adj_eff = adj_in | (self_loop ? diag_mask() : '0);
    assign src_x   = x_q[int'(cnt_q)*NW +: NW];

    // FSM next state and source counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_rdy_agg) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (cnt_q == CW'(N_NODES - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and captured job registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            adj_q   <= '0;
            mode_q  <= SUM;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                x_q    <= x_in;
                adj_q  <= adj_eff;
                mode_q <= mode_e'(mode);
            end
        end
    end

    for (genvar i = 0; i < N_NODES; i++) begin : g_node
        logic [N_NODES-1:0] row;
        logic               en;
        assign row = adj_q[i*N_NODES +: N_NODES];
        assign en  = (state_q == ACCUM) && row[cnt_q];
        gnn_agg_node_acc #(
            .N_FEAT (N_FEAT),
            .IW     (IW),
            .OW     (OW)
        ) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .init_i (accept),
            .en_i   (en),
            .mode_i (mode_q),
            .x_i    (src_x),
            .acc_o  (acc_all[i*NOW +: NOW])
        );
    end

    assign in_ack      = (state_q == IDLE);
    assign out_rdy_agg = (state_q == HOLD);
    assign x_agg       = out_rdy_agg ? acc_all : '0;

endmodule

// File: tb/tb_gnn_aggregator_param.sv
// Self-checking bench for gnn_aggregator_param (4x4 default and 8x2 build).
// Scoreboard queue of expected results, checked when out_rdy_agg rises.
module tb_gnn_aggregator_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         s_in_rdy, s_in_ack, s_sl, s_mode, s_out_rdy, s_out_ack;
    logic [79:0]  s_x;
    logic [15:0]  s_adj;
    logic [335:0] s_xagg;

    logic         b_in_rdy, b_in_ack, b_sl, b_mode, b_out_rdy, b_out_ack;
    logic [127:0] b_x;
    logic [63:0]  b_adj;
    logic [191:0] b_xagg;

    gnn_aggregator_param u_small (
        .clk(clk), .rst_n(rst_n),
        .in_rdy_agg(s_in_rdy), .in_ack(s_in_ack),
        .x_in(s_x), .adj_in(s_adj), .self_loop(s_sl), .mode(s_mode),
        .out_rdy_agg(s_out_rdy), .out_ack(s_out_ack), .x_agg(s_xagg)
    );

    gnn_aggregator_param #(
        .N_NODES(8), .N_FEAT(2), .IW(8), .OW(12)
    ) u_big (
        .clk(clk), .rst_n(rst_n),
        .in_rdy_agg(b_in_rdy), .in_ack(b_in_ack),
        .x_in(b_x), .adj_in(b_adj), .self_loop(b_sl), .mode(b_mode),
        .out_rdy_agg(b_out_rdy), .out_ack(b_out_ack), .x_agg(b_xagg)
    );

    typedef struct {
        int v[8][4];
        bit big;
    } exp_t;

    exp_t sb[$];
    int   xv[8][4];
    int   n_run = 0;
    int   n_fail = 0;

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    // Reference: aggregate each destination over its incoming edges.
    function automatic exp_t model(bit big, logic [63:0] adj, bit sl, bit md);
        exp_t e;
        int n, nf, acc;
        bit any;
        n  = big ? 8 : 4;
        nf = big ? 2 : 4;
        e.big = big;
        for (int i = 0; i < 8; i++)
            for (int f = 0; f < 4; f++) e.v[i][f] = 0;
        for (int i = 0; i < n; i++)
            for (int f = 0; f < nf; f++) begin
                acc = 0;
                any = 0;
                for (int j = 0; j < n; j++)
                    if (adj[i*n+j] || (sl && i == j)) begin
                        if (!md) acc += xv[j][f];
                        else if (!any || xv[j][f] > acc) acc = xv[j][f];
                        any = 1;
                    end
                e.v[i][f] = acc;
            end
        return e;
    endfunction

    function automatic int got(bit big, int i, int f);
        logic signed [20:0] a;
        logic signed [11:0] b;
        if (big) begin
            b = b_xagg[(i*2+f)*12 +: 12];
            return int'(b);
        end
        a = s_xagg[(i*4+f)*21 +: 21];
        return int'(a);
    endfunction

    function automatic int count_bad(exp_t e, output int bi, output int bf);
        int n, nf, c;
        n  = e.big ? 8 : 4;
        nf = e.big ? 2 : 4;
        c = 0; bi = 0; bf = 0;
        for (int i = 0; i < n; i++)
            for (int f = 0; f < nf; f++)
                if (got(e.big, i, f) != e.v[i][f]) begin
                    if (c == 0) begin bi = i; bf = f; end
                    c++;
                end
        return c;
    endfunction

    task automatic start_job(bit big, bit sl, bit md, logic [63:0] adj);
        int t;
        @(negedge clk);
        if (big) begin
            for (int i = 0; i < 8; i++)
                for (int f = 0; f < 2; f++) begin
                    t = xv[i][f];
                    b_x[(i*2+f)*8 +: 8] = t[7:0];
                end
            b_adj = adj; b_sl = sl; b_mode = md; b_in_rdy = 1;
        end else begin
            for (int i = 0; i < 4; i++)
                for (int f = 0; f < 4; f++) begin
                    t = xv[i][f];
                    s_x[(i*4+f)*5 +: 5] = t[4:0];
                end
            s_adj = adj[15:0]; s_sl = sl; s_mode = md; s_in_rdy = 1;
        end
        sb.push_back(model(big, adj, sl, md));
        @(posedge clk);
        @(negedge clk);
        if (big) begin
            b_in_rdy = 0;
            b_x = {$urandom(), $urandom(), $urandom(), $urandom()};
            b_adj = {$urandom(), $urandom()};
            b_sl = 1'($urandom()); b_mode = 1'($urandom());
        end else begin
            s_in_rdy = 0;
            s_x = {$urandom(), $urandom(), 16'($urandom())};
            s_adj = 16'($urandom());
            s_sl = 1'($urandom()); s_mode = 1'($urandom());
        end
    endtask

    task automatic wait_out(bit big, output int lat);
        lat = 0;
        while (!(big ? b_out_rdy : s_out_rdy) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic ack_out(bit big);
        if (big) b_out_ack = 1; else s_out_ack = 1;
        @(posedge clk);
        @(negedge clk);
        if (big) b_out_ack = 0; else s_out_ack = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        n_run++;
        if (s_in_ack !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ack got %b want 1", s_in_ack);
        end
        n_run++;
        if (s_out_rdy !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_rdy got %b want 0", s_out_rdy);
        end
        n_run++;
        if (s_xagg !== '0) begin
            n_fail++; $display("FAIL reset_x_agg got %h want 0", s_xagg);
        end
        n_run++;
        if (b_in_ack !== 1'b1 || b_out_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_big got ack=%b rdy=%b want 1/0", b_in_ack, b_out_rdy);
        end
    endtask

    task automatic test_sum_ring();
        int lat, bi, bf, nb;
        exp_t e;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++)
                xv[i][f] = (f == 0) ? i + 1 : rnd(-16, 15);
        start_job(0, 1, 0, 64'h6996);
        wait_out(0, lat);
        n_run++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL ring_latency got %0d want 4", lat);
        end
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (got(0, i, 0) !== i + 6) begin
                n_fail++;
                $display("FAIL ring_feat0 n%0d got %0d want %0d", i, got(0, i, 0), i + 6);
            end
        end
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL ring_sb n%0d f%0d got %0d want %0d",
                     bi, bf, got(0, bi, bf), e.v[bi][bf]);
        end
        ack_out(0);
        n_run++;
        if (s_in_ack !== 1'b1 || s_xagg !== '0) begin
            n_fail++;
            $display("FAIL ring_release got ack=%b xagg=%h want 1/0", s_in_ack, s_xagg);
        end
    endtask

    task automatic test_sum_neg();
        int lat, bi, bf, nb, bad;
        exp_t e;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) xv[i][f] = -16;
        start_job(0, 0, 0, 64'hFFFF);
        wait_out(0, lat);
        bad = 0;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++)
                if (got(0, i, f) != -64) bad++;
        n_run++;
        if (bad !== 0 || lat !== 4) begin
            n_fail++;
            $display("FAIL neg_sum got %0d lat %0d want -64 lat 4", got(0, 0, 0), lat);
        end
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL neg_sb n%0d f%0d got %0d want %0d",
                     bi, bf, got(0, bi, bf), e.v[bi][bf]);
        end
        ack_out(0);
    endtask

    task automatic test_max();
        int lat, bi, bf, nb;
        logic [63:0] adj;
        exp_t e;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) xv[i][f] = rnd(-16, 15);
        for (int f = 0; f < 4; f++) begin
            xv[1][f] = 5;
            xv[2][f] = -3;
        end
        adj = {48'h0, 4'h0, 8'($urandom()), 4'b0110};
        start_job(0, 0, 1, adj);
        wait_out(0, lat);
        for (int f = 0; f < 4; f++) begin
            n_run++;
            if (got(0, 0, f) !== 5 || got(0, 3, f) !== 0) begin
                n_fail++;
                $display("FAIL max_f%0d got n0=%0d n3=%0d want 5/0",
                         f, got(0, 0, f), got(0, 3, f));
            end
        end
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL max_sb n%0d f%0d got %0d want %0d",
                     bi, bf, got(0, bi, bf), e.v[bi][bf]);
        end
        ack_out(0);
    endtask

    task automatic test_hold();
        int lat, bi, bf, nb;
        logic [335:0] snap;
        exp_t e;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) xv[i][f] = rnd(-16, 15);
        start_job(0, 1, 0, {48'h0, 16'($urandom())});
        wait_out(0, lat);
        snap = s_xagg;
        for (int k = 0; k < 10; k++) begin
            s_in_rdy = ~s_in_rdy;
            @(posedge clk);
            @(negedge clk);
            n_run++;
            if (s_xagg !== snap || s_in_ack !== 1'b0 || s_out_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_c%0d got ack=%b rdy=%b stable=%b want 0/1/1",
                         k, s_in_ack, s_out_rdy, s_xagg === snap);
            end
        end
        s_in_rdy = 0;
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL hold_sb n%0d f%0d got %0d want %0d",
                     bi, bf, got(0, bi, bf), e.v[bi][bf]);
        end
        ack_out(0);
        n_run++;
        if (s_in_ack !== 1'b1 || s_out_rdy !== 1'b0 || s_xagg !== '0) begin
            n_fail++;
            $display("FAIL hold_release got ack=%b rdy=%b xagg=%h want 1/0/0",
                     s_in_ack, s_out_rdy, s_xagg);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bi, bf, nb;
        exp_t e;
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) xv[i][f] = rnd(-16, 15);
        start_job(0, 1, 0, 64'hFFFF);
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        void'(sb.pop_back());
        n_run++;
        if (s_out_rdy !== 1'b0 || s_xagg !== '0 || s_in_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst got rdy=%b ack=%b xagg=%h want 0/1/0",
                     s_out_rdy, s_in_ack, s_xagg);
        end
        for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) xv[i][f] = rnd(-16, 15);
        start_job(0, 0, 1, {48'h0, 16'($urandom())});
        wait_out(0, lat);
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0 || lat !== 4) begin
            n_fail++;
            $display("FAIL midrst_job n%0d f%0d got %0d lat %0d want %0d lat 4",
                     bi, bf, got(0, bi, bf), lat, e.v[bi][bf]);
        end
        ack_out(0);
    endtask

    task automatic test_back_to_back();
        int lat, bi, bf, nb;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++)
                for (int f = 0; f < 4; f++) xv[i][f] = rnd(-16, 15);
            start_job(0, 1'($urandom()), 1'($urandom()), {48'h0, 16'($urandom())});
            wait_out(0, lat);
            e = sb.pop_front();
            nb = count_bad(e, bi, bf);
            n_run++;
            if (nb !== 0 || lat !== 4) begin
                n_fail++;
                $display("FAIL b2b_%0d n%0d f%0d got %0d lat %0d want %0d lat 4",
                         k, bi, bf, got(0, bi, bf), lat, e.v[bi][bf]);
            end
            ack_out(0);
        end
    endtask

    task automatic test_big();
        int lat, bi, bf, nb, bad;
        exp_t e;
        for (int i = 0; i < 8; i++)
            for (int f = 0; f < 2; f++) xv[i][f] = 127;
        start_job(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_out(1, lat);
        n_run++;
        if (lat !== 8) begin
            n_fail++; $display("FAIL big_latency got %0d want 8", lat);
        end
        bad = 0;
        for (int i = 0; i < 8; i++)
            for (int f = 0; f < 2; f++)
                if (got(1, i, f) != 1016) bad++;
        n_run++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL big_sum got %0d want 1016", got(1, 0, 0));
        end
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0) begin
            n_fail++;
            $display("FAIL big_sb n%0d f%0d got %0d want %0d",
                     bi, bf, got(1, bi, bf), e.v[bi][bf]);
        end
        ack_out(1);
        for (int i = 0; i < 8; i++)
            for (int f = 0; f < 2; f++) xv[i][f] = rnd(-128, 127);
        start_job(1, 1'($urandom()), 1, {$urandom(), $urandom()});
        wait_out(1, lat);
        e = sb.pop_front();
        nb = count_bad(e, bi, bf);
        n_run++;
        if (nb !== 0 || lat !== 8) begin
            n_fail++;
            $display("FAIL big_max n%0d f%0d got %0d lat %0d want %0d lat 8",
                     bi, bf, got(1, bi, bf), lat, e.v[bi][bf]);
        end
        ack_out(1);
        n_run++;
        if (b_in_ack !== 1'b1 || b_xagg !== '0) begin
            n_fail++;
            $display("FAIL big_release got ack=%b xagg=%h want 1/0", b_in_ack, b_xagg);
        end
    endtask

    initial begin
        rst_n = 0;
        s_in_rdy = 0; s_out_ack = 0; s_x = '0; s_adj = '0; s_sl = 0; s_mode = 0;
        b_in_rdy = 0; b_out_ack = 0; b_x = '0; b_adj = '0; b_sl = 0; b_mode = 0;
        test_reset();
        test_sum_ring();
        test_sum_neg();
        test_max();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_big();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/gnn_aggregator_param.md
GNN_AGGREGATOR_PARAM -- requirements
Module: gnn_aggregator_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 The block SHALL expose these parameters:
- N_NODES, default 4, number of graph nodes.
- N_FEAT, default 4, features per node.
- IW, default 5, signed input feature width.
- OW, default 21, signed output width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_rdy_agg  in  1  input valid.
- in_ack  out  1  input ready.
- x_in  in  N_NODES*N_FEAT*IW  node features, node-major, feature-minor, signed.
- adj_in  in  N_NODES*N_NODES  adjacency; bit [i*N_NODES+j] means node j feeds node i.
- self_loop  in  1  forces the diagonal to 1.
- mode  in  1  0 = SUM, 1 = MAX.
- out_rdy_agg  out  1  result valid.
- out_ack  in  1  result consumed.
- x_agg  out  N_NODES*N_FEAT*OW  aggregated features, same packing as x_in.

Function
REQ-004 The FSM SHALL have states IDLE, ACCUM and HOLD; in_ack SHALL be 1 only in IDLE.
REQ-005 IDLE->ACCUM SHALL occur on the edge where in_rdy_agg && in_ack; that edge registers x_in, the effective adjacency (adj_in OR diagonal if self_loop) and mode, and initialises the accumulators.
REQ-006 In ACCUM, source counter j SHALL run 0..N_NODES-1, one per cycle; each edge applies source j to every destination i where adjacency bit [i][j]=1.
REQ-007 SUM mode SHALL accumulate acc[i][f] += sext(x[j][f]) at width OW; the initial value SHALL be 0.
REQ-008 MAX mode SHALL compute acc[i][f] = max(acc[i][f], sext(x[j][f])) as a signed compare.
REQ-009 In MAX mode, a destination with no contributing source SHALL output 0.
REQ-010 ACCUM->HOLD SHALL occur on the edge that applies j=N_NODES-1; out_rdy_agg SHALL be 1 exactly N_NODES cycles after the acceptance edge.
REQ-011 In HOLD, out_rdy_agg and x_agg SHALL remain stable until out_ack=1 at a clock edge; that edge SHALL go to IDLE, with in_ack=1 in the following cycle.
REQ-012 x_agg SHALL be driven as all-zero whenever out_rdy_agg=0.
REQ-013 in_rdy_agg SHALL be ignored outside IDLE; changes to x_in, adj_in, self_loop and mode after acceptance SHALL have no effect on the result.
REQ-014 out_ack SHALL be ignored outside HOLD.
REQ-015 Elaboration SHALL fail if OW < IW + $clog2(N_NODES+1); given that check, SUM mode cannot overflow and no saturation logic SHALL exist.
REQ-016 N_NODES=1 SHALL be supported: ACCUM lasts 1 cycle.

Reset
REQ-017 When rst_n=0 at a clock edge, the block SHALL enter IDLE with out_rdy_agg=0, x_agg=0, in_ack=1 in the following cycle, the counter at 0 and the accumulators at 0.
REQ-018 Reset SHALL take priority over every other event, including mid-ACCUM and mid-HOLD; any partial result SHALL be discarded.

Structure
REQ-019 A shared package gnn_agg_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD), the mode enum (SUM/MAX) and the width-check function.
REQ-020 One sub-module, gnn_agg_node_acc, SHALL hold the N_FEAT accumulators for one destination node (enable, source features, mode, init); the top SHALL instantiate N_NODES copies in a generate loop.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Defaults, SUM, self_loop=1, adjacency n0<-{n1,n2}, n1<-{n3,n0}, n2<-{n3,n0}, n3<-{n1,n2}, feature 0 = 1,2,3,4 for n0..n3 -> feature 0 out = 6,7,8,9; out_rdy_agg rises 4 cycles after acceptance.
- SUM, full adjacency, all features = -16 -> every output = -64; sign extension correct.
- MAX, self_loop=0, n3 row all zero, n0 <- {n1=5, n2=-3} -> n0 = 5, n3 = 0.
- out_ack held low 10 cycles in HOLD while in_rdy_agg toggles -> x_agg stable, in_ack=0; out_ack=1 -> IDLE, in_ack=1 the next cycle, x_agg=0.
- rst_n=0 during the second ACCUM cycle -> next cycle out_rdy_agg=0, x_agg=0, in_ack=1; a new job after reset gives the correct result.
- N_NODES=8, N_FEAT=2, IW=8, OW=12, SUM, full adjacency, all features = 127 -> outputs 1016; latency 8 cycles.
